// File: rtl/qft_pkg.sv
// qft_pkg: widths, twiddle table, FSM encoding and Q7.5 -> integer requantiser for the QFT sequencer
package qft_pkg;
    localparam int MAX_K = 8;
    localparam int AMP_W = 8;
    localparam int TW_W  = 12;
    localparam int FB_W  = 13;
    localparam int K_W   = 4;
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    // {cos, sin} of 2*pi/2^k in Q1.10; unused indices read as zero
    localparam logic [2*TW_W-1:0] TW_ROM [16] = '{
        1: {-12'sd1024, 12'sd0},
        2: {12'sd0,     12'sd1024},
        3: {12'sd724,   12'sd724},
        4: {12'sd946,   12'sd392},
        5: {12'sd1004,  12'sd200},
        6: {12'sd1019,  12'sd100},
        7: {12'sd1023,  12'sd50},
        8: {12'sd1024,  12'sd25},
        default: '0
    };
    function automatic logic signed [AMP_W-1:0] requant(input logic signed [FB_W-1:0] x);
        logic signed [FB_W:0] t;
        t = ($signed({x[FB_W-1], x}) + 14'sd16) >>> 5;
        return t > 14'sd127 ? 8'sd127 : t < -14'sd128 ? -8'sd128 : t[AMP_W-1:0];
    endfunction
endpackage

// File: rtl/qft_rotation_sequencer_rom.sv
// qft_twiddle_rom: combinational rotation index -> {cos, sin} lookup
module qft_twiddle_rom
    import qft_pkg::*;
(
    input  logic        [K_W-1:0]  k_idx,
    output logic signed [TW_W-1:0] cos_v,
    output logic signed [TW_W-1:0] sin_v
);
    assign {cos_v, sin_v} = TW_ROM[k_idx];
endmodule

// File: rtl/qft_rotation_sequencer.sv
// qft_rotation_sequencer: steps R_2..R_n twiddles into a complex multiplier and folds its result back
module qft_rotation_sequencer
    import qft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic        [K_W-1:0]   n_qubits,
    input  logic signed [AMP_W-1:0] in_r,
    input  logic signed [AMP_W-1:0] in_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [TW_W-1:0]  cos_2p_by,
    output logic signed [TW_W-1:0]  sin_2p_by,
    output logic signed [AMP_W-1:0] amp_r,
    output logic signed [AMP_W-1:0] amp_i,
    output logic        [K_W-1:0]   k_idx,
    output logic                    last,
    input  logic signed [FB_W-1:0]  fb_r,
    input  logic signed [FB_W-1:0]  fb_i,
    output logic                    busy,
    output logic                    done,
    output logic signed [AMP_W-1:0] res_r,
    output logic signed [AMP_W-1:0] res_i,
    output logic                    err
);
    state_t         state, state_nx;
    logic [K_W-1:0] n_lat;
    logic           n_ok, go, acc;
    qft_twiddle_rom u_rom (.k_idx(k_idx), .cos_v(cos_2p_by), .sin_v(sin_2p_by));
    always_comb begin
        n_ok      = n_qubits >= 4'd2 && n_qubits <= 4'(MAX_K);
        go        = state == IDLE && start && n_ok;
        out_valid = state == EMIT;
        busy      = state == EMIT;
        done      = state == DONE;
        last      = state == EMIT && k_idx == n_lat;
        acc       = out_valid && out_ready;
        state_nx  = state == IDLE ? (go ? EMIT : IDLE) :
                    state == EMIT ? (acc && last ? DONE : EMIT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat <= '0;
            k_idx <= '0;
            amp_r <= '0;
            amp_i <= '0;
            res_r <= '0;
            res_i <= '0;
            err   <= 1'b0;
        end else begin
            err <= state == IDLE && start && !n_ok;
            if (go) begin
                n_lat <= n_qubits;
                amp_r <= in_r;
                amp_i <= in_i;
                k_idx <= 4'd2;
            end else if (acc) begin
                amp_r <= requant(fb_r);
                amp_i <= requant(fb_i);
                if (last) begin
                    res_r <= requant(fb_r);
                    res_i <= requant(fb_i);
                end else k_idx <= k_idx + 4'd1;
            end
        end
    end
endmodule
